// File: rtl/mem_access_unit.sv
// mem_access_unit: fetch/data-read sequencer between the control FSM and memory.
// Owns PC, instruction and data registers, the memory request and the wait timeout.
module mem_access_unit #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter int                TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             AdrSrc,
  input  logic             IRWrite,
  input  logic             MemRead,
  input  logic             NextPC,
  input  logic [WIDTH-1:0] Result,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] Instr,
  output logic [WIDTH-1:0] Data,
  output logic             Stall,
  output logic             bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          req;
  logic          fetch_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          start;
  logic          capture;
  logic          tmo;
  logic          cnt_en;

  assign req     = IRWrite | MemRead;
  assign cnt_inc = cnt + CW'(1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, stall and datapath enables
  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    start     = 1'b0;
    capture   = 1'b0;
    tmo       = 1'b0;
    cnt_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          Stall     = 1'b1;
          start     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        Stall = 1'b1;
        if (mem_ready) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_inc == TMAX) begin
            tmo       = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request, address, capture registers, counter, PC and error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      fetch_q  <= 1'b0;
      cnt      <= '0;
      PC       <= RESET_PC;
      Instr    <= '0;
      Data     <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (start) begin
        mem_req  <= 1'b1;
        mem_addr <= AdrSrc ? ALUOut : PC;
        fetch_q  <= IRWrite;
        cnt      <= '0;
      end
      if (cnt_en) cnt <= cnt_inc;
      if (capture || tmo) mem_req <= 1'b0;
      if (capture) begin
        if (fetch_q) Instr <= mem_rdata;
        else         Data  <= mem_rdata;
      end
      if (tmo) bus_err <= 1'b1;
      if (NextPC && !Stall) PC <= Result;
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WIDTH, default 32: data and address width.
REQ-002 Parameter RESET_PC, default 0: PC value after reset.
REQ-003 Parameter TIMEOUT, default 255: maximum number of WAIT cycles before a bus error is raised.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 AdrSrc  input  1  address select from the control FSM: 0 = PC, 1 = ALUOut.
REQ-007 IRWrite  input  1  fetch request from the control FSM.
REQ-008 MemRead  input  1  data-read request from the control FSM.
REQ-009 NextPC  input  1  PC write enable from the control FSM.
REQ-010 Result  input  WIDTH  result-mux value (next PC during fetch).
REQ-011 ALUOut  input  WIDTH  computed data address.
REQ-012 mem_rdata  input  WIDTH  memory read data.
REQ-013 mem_ready  input  1  memory completion strobe.
REQ-014 mem_req  output  1  registered memory request.
REQ-015 mem_addr  output  WIDTH  registered memory address.
REQ-016 PC  output  WIDTH  program counter.
REQ-017 Instr  output  WIDTH  instruction register.
REQ-018 Data  output  WIDTH  memory data register.
REQ-019 Stall  output  1  high = the control FSM shall hold its current state.
REQ-020 bus_err  output  1  sticky timeout flag.

Function
REQ-021 States: IDLE, WAIT, DONE, held in a registered state variable.
REQ-022 A request is present when (IRWrite | MemRead) = 1.
- Fetch is IRWrite = 1.
- Read is MemRead = 1 with IRWrite = 0.
- When both are high, fetch wins.
REQ-023 IDLE with a request present: on the next edge, go to WAIT.
- mem_req <= 1.
- mem_addr <= (AdrSrc ? ALUOut : PC).
- Latch the access kind (fetch or read).
- Clear the wait counter.
REQ-024 WAIT with mem_ready = 1: on the next edge, go to DONE with mem_req <= 0.
- Fetch: Instr <= mem_rdata.
- Read: Data <= mem_rdata.
REQ-025 WAIT with mem_ready = 0: increment the wait counter.
- When the counter equals TIMEOUT: go to DONE, set bus_err <= 1, drop mem_req.
- Instr and Data are left unchanged on timeout.
REQ-026 DONE: always go to IDLE on the next edge.
REQ-027 Stall = 1 in WAIT, and in IDLE while a request is present; Stall = 0 otherwise (DONE, or IDLE with no request).
REQ-028 PC <= Result on any edge where NextPC = 1 and Stall = 0; PC is held otherwise.
REQ-029 Minimum access latency, measured from the request edge:
- 2 stall cycles, then the DONE cycle.
- mem_ready is sampled only in WAIT; mem_ready in IDLE or DONE is ignored.
REQ-030 Back-to-back: a request still present in the IDLE cycle after DONE starts a new access. A new access starts only from IDLE.
REQ-031 mem_addr, the latched kind, Instr and Data change only on the edges defined in REQ-023 to REQ-025.
REQ-032 bus_err stays at 1 until reset; once set, it does not block further accesses.

Reset
REQ-033 reset = 0 forces the following asynchronously, regardless of state:
- state = IDLE.
- mem_req = 0, mem_addr = 0.
- PC = RESET_PC.
- Instr = 0, Data = 0.
- bus_err = 0.
- wait counter = 0.
REQ-034 Reset asserted during WAIT abandons the access:
- mem_req drops in the same cycle.
- No register capture occurs.
- After release, the unit starts from IDLE.

Verification
REQ-035 Fetch, zero-wait: PC = 0, Result = 4, IRWrite = NextPC = 1, mem_rdata = 0xE5912004, mem_ready high in WAIT. Required response:
- mem_addr = 0.
- Stall high for 2 cycles.
- Instr = 0xE5912004.
- PC = 4 after the DONE edge.
REQ-036 Data read with 3 wait cycles: AdrSrc = 1, MemRead = 1, ALUOut = 0x100, mem_ready high on the 4th WAIT cycle, mem_rdata = 0xDEADBEEF. Required response:
- mem_addr = 0x100.
- Stall high for 5 cycles.
- Data = 0xDEADBEEF.
- Instr unchanged.
REQ-037 Simultaneous IRWrite = MemRead = 1: the access is treated as a fetch; Instr is written and Data is unchanged.
REQ-038 Timeout: mem_ready held low with TIMEOUT = 4. Required response:
- Counter reaches 4, then DONE with bus_err = 1.
- Data unchanged.
- The next request proceeds normally.
- bus_err stays 1 until reset.
REQ-039 Reset = 0 asserted mid-WAIT. Required response:
- mem_req = 0 and PC = RESET_PC immediately.
- Instr = Data = 0.
- After release, a fetch completes normally.
REQ-040 No request (IRWrite = MemRead = 0) with NextPC = 1: Stall = 0 and PC <= Result every cycle; mem_req stays 0.
